// File: rtl/parking_pkg.sv
// Shared types, default parameters and width helpers for the parking entrance controller.
package parking_pkg;

  localparam int unsigned DEF_PIN_W        = 8;
  localparam int unsigned DEF_PIN_CODE     = 72;
  localparam int unsigned DEF_MAX_TRIES    = 3;
  localparam int unsigned DEF_OPEN_TIMEOUT = 64;
  localparam int unsigned DEF_CLOSE_CYCLES = 4;
  localparam int unsigned DEF_CAPACITY     = 16;

  localparam int unsigned ST_W = 6;

  // One-hot gate states; any illegal encoding is steered back to ST_IDLE.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE         = 6'b000001,
    ST_WAIT_PIN     = 6'b000010,
    ST_GATE_OPEN    = 6'b000100,
    ST_GATE_CLOSING = 6'b001000,
    ST_PIN_ALARM    = 6'b010000,
    ST_GATE_BLOCK   = 6'b100000
  } state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned occ_w(input int unsigned capacity);
    return cnt_w(capacity);
  endfunction

endpackage

// File: rtl/lot_occupancy_counter.sv
// Lot occupancy counter: saturates at CAPACITY and at zero; a simultaneous inc and dec leave the count unchanged.
module lot_occupancy_counter
  import parking_pkg::*;
#(
  parameter  int unsigned CAPACITY = DEF_CAPACITY,
  localparam int unsigned OCC_W    = occ_w(CAPACITY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] count,
  output logic             full
);

  localparam logic [OCC_W-1:0] CAP_VAL = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != CAP_VAL) count_d = count_q + OCC_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == CAP_VAL);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking entrance controller: PIN check with attempt limit, timed gate open/close,
// tailgate detection and lot occupancy tracking.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter  int unsigned PIN_W        = DEF_PIN_W,
  parameter  int unsigned PIN_CODE     = DEF_PIN_CODE,
  parameter  int unsigned MAX_TRIES    = DEF_MAX_TRIES,
  parameter  int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter  int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter  int unsigned CAPACITY     = DEF_CAPACITY,
  localparam int unsigned OCC_W        = occ_w(CAPACITY),
  localparam int unsigned TRY_W        = cnt_w(MAX_TRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             senr_e,
  input  logic             senr_x,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             car_left,
  output logic             gate_o,
  output logic             gate_cls,
  output logic             alm_pin,
  output logic             alm_blkg,
  output logic             lot_full,
  output logic [OCC_W-1:0] occupancy,
  output logic [TRY_W-1:0] tries
);

  localparam int unsigned TMR_MAX = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  localparam logic [PIN_W-1:0] PIN_VAL    = PIN_W'(PIN_CODE);
  localparam logic [TRY_W-1:0] TRY_LIMIT  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [TRY_W-1:0] tries_q;
  logic [TRY_W-1:0] tries_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;

  logic             pin_ok;
  logic             both_sensors;
  logic             occ_inc;
  logic [TRY_W-1:0] tries_inc;

  assign pin_ok       = pin_valid && (pin == PIN_VAL);
  assign both_sensors = senr_e && senr_x;
  assign tries_inc    = tries_q + TRY_W'(1);

  // Next-state logic; the timer defaults to zero so every state entry restarts it.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = '0;
    occ_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (senr_e && !senr_x && !lot_full) state_d = ST_WAIT_PIN;
      end
      ST_WAIT_PIN: begin
        if (pin_valid) begin
          if (pin_ok) begin
            state_d = ST_GATE_OPEN;
            tries_d = '0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIMIT) state_d = ST_PIN_ALARM;
          end
        end else if (!senr_e) begin
          state_d = ST_IDLE;
          tries_d = '0;
        end
      end
      ST_GATE_OPEN: begin
        if (both_sensors) begin
          state_d = ST_GATE_BLOCK;
        end else if (senr_x) begin
          state_d = ST_GATE_CLOSING;
          occ_inc = 1'b1;
        end else if (timer_q == OPEN_LAST) begin
          state_d = ST_GATE_CLOSING;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GATE_CLOSING: begin
        if (both_sensors) begin
          state_d = ST_GATE_BLOCK;
        end else if (timer_q == CLOSE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_PIN_ALARM: begin
        if (pin_ok) begin
          state_d = ST_IDLE;
          tries_d = '0;
        end
      end
      ST_GATE_BLOCK: begin
        if (pin_ok && !senr_e && !senr_x) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tries_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tries_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
    end
  end

  lot_occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk   (clock),
    .rst_n (reset),
    .inc   (occ_inc),
    .dec   (car_left),
    .count (occupancy),
    .full  (lot_full)
  );

  assign gate_o   = (state_q == ST_GATE_OPEN);
  assign gate_cls = (state_q == ST_GATE_CLOSING) || (state_q == ST_GATE_BLOCK);
  assign alm_pin  = (state_q == ST_PIN_ALARM);
  assign alm_blkg = (state_q == ST_GATE_BLOCK);
  assign tries    = tries_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_parking_gate_ctrl;

  localparam int unsigned PIN_W        = 8;
  localparam int unsigned PIN_CODE     = 72;
  localparam int unsigned MAX_TRIES    = 3;
  localparam int unsigned OPEN_TIMEOUT = 64;
  localparam int unsigned CLOSE_CYCLES = 4;
  localparam int unsigned CAPACITY     = 16;
  localparam int unsigned OCC_W        = 5;
  localparam int unsigned TRY_W        = 2;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             senr_e    = 1'b0;
  logic             senr_x    = 1'b0;
  logic [PIN_W-1:0] pin       = '0;
  logic             pin_valid = 1'b0;
  logic             car_left  = 1'b0;
  logic             gate_o;
  logic             gate_cls;
  logic             alm_pin;
  logic             alm_blkg;
  logic             lot_full;
  logic [OCC_W-1:0] occupancy;
  logic [TRY_W-1:0] tries;

  parking_gate_ctrl #(
    .PIN_W        (PIN_W),
    .PIN_CODE     (PIN_CODE),
    .MAX_TRIES    (MAX_TRIES),
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CLOSE_CYCLES (CLOSE_CYCLES),
    .CAPACITY     (CAPACITY)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .senr_e    (senr_e),
    .senr_x    (senr_x),
    .pin       (pin),
    .pin_valid (pin_valid),
    .car_left  (car_left),
    .gate_o    (gate_o),
    .gate_cls  (gate_cls),
    .alm_pin   (alm_pin),
    .alm_blkg  (alm_blkg),
    .lot_full  (lot_full),
    .occupancy (occupancy),
    .tries     (tries)
  );

  always #5 clock = ~clock;

  // Behavioural model: a named phase, how long it has lasted, the car count and the wrong-PIN count.
  typedef enum {M_IDLE, M_WAIT, M_OPEN, M_CLOSE, M_ALARM, M_BLOCK} phase_t;
  phase_t m_phase = M_IDLE;
  int     m_age   = 0;
  int     m_cars  = 0;
  int     m_wrong = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit e, input bit x, input bit pv,
                            input int p, input bit cl);
    phase_t nxt;
    bit     arrived;
    bool_pin: begin end
    if (!rst_n) begin
      m_phase = M_IDLE;
      m_age   = 0;
      m_cars  = 0;
      m_wrong = 0;
      return;
    end
    nxt     = m_phase;
    arrived = 1'b0;
    case (m_phase)
      M_IDLE:  if (e && !x && m_cars < CAPACITY) nxt = M_WAIT;
      M_WAIT: begin
        if (pv) begin
          if (p == PIN_CODE) begin
            nxt = M_OPEN;
            m_wrong = 0;
          end else begin
            m_wrong++;
            if (m_wrong == MAX_TRIES) nxt = M_ALARM;
          end
        end else if (!e) begin
          nxt = M_IDLE;
          m_wrong = 0;
        end
      end
      M_OPEN: begin
        if (e && x) nxt = M_BLOCK;
        else if (x) begin
          nxt = M_CLOSE;
          arrived = 1'b1;
        end else if (m_age + 1 >= OPEN_TIMEOUT) nxt = M_CLOSE;
      end
      M_CLOSE: begin
        if (e && x) nxt = M_BLOCK;
        else if (m_age + 1 >= CLOSE_CYCLES) nxt = M_IDLE;
      end
      M_ALARM: if (pv && p == PIN_CODE) begin
        nxt = M_IDLE;
        m_wrong = 0;
      end
      M_BLOCK: if (pv && p == PIN_CODE && !e && !x) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (arrived && !cl) m_cars = (m_cars < CAPACITY) ? m_cars + 1 : m_cars;
    else if (cl && !arrived && m_cars > 0) m_cars--;
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic step(input bit rst_n, input bit e, input bit x, input bit pv,
                      input int p, input bit cl);
    reset     = rst_n;
    senr_e    = e;
    senr_x    = x;
    pin_valid = pv;
    pin       = PIN_W'(p);
    car_left  = cl;
    @(posedge clock);
    model_step(rst_n, e, x, pv, p, cl);
    @(negedge clock);
    check("gate_o",    int'(gate_o),    int'(m_phase == M_OPEN));
    check("gate_cls",  int'(gate_cls),  int'(m_phase == M_CLOSE || m_phase == M_BLOCK));
    check("alm_pin",   int'(alm_pin),   int'(m_phase == M_ALARM));
    check("alm_blkg",  int'(alm_blkg),  int'(m_phase == M_BLOCK));
    check("lot_full",  int'(lot_full),  int'(m_cars == CAPACITY));
    check("occupancy", int'(occupancy), m_cars);
    check("tries",     int'(tries),     m_wrong);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // Full entry of one car: arrive, good PIN, drive through, wait out the close.
  task automatic admit_car(input bit cl_on_pass);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, PIN_CODE, 0);
    step(1, 0, 1, 0, 0, cl_on_pass);
    idle(CLOSE_CYCLES);
  endtask

  initial begin
    int r_e, r_x, r_pv, r_p, r_cl, r_rst, sel;

    // Reset held low with a car at the sensor.
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_tries", int'(tries), 0);
    check("rst_gate_o", int'(gate_o), 0);
    step(1, 0, 0, 1, PIN_CODE, 0);
    check("rst_no_open", int'(gate_o), 0);

    // Normal entry.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, PIN_CODE, 0);
    check("entry_open", int'(gate_o), 1);
    step(1, 0, 1, 0, 0, 0);
    check("entry_cls", int'(gate_cls), 1);
    check("entry_occ", int'(occupancy), 1);
    idle(CLOSE_CYCLES - 1);
    check("entry_cls_held", int'(gate_cls), 1);
    idle(1);
    check("entry_cls_done", int'(gate_cls), 0);

    // Wrong PINs up to the alarm, then recovery.
    step(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= MAX_TRIES; i++) begin
      step(1, 1, 0, 1, PIN_CODE - 1, 0);
      check("tries_count", int'(tries), i);
    end
    check("alarm_on", int'(alm_pin), 1);
    step(1, 1, 0, 1, 0, 0);
    check("alarm_sat", int'(tries), MAX_TRIES);
    step(1, 1, 0, 1, PIN_CODE, 0);
    check("alarm_off", int'(alm_pin), 0);
    check("alarm_tries_clr", int'(tries), 0);
    idle(2);

    // Tailgate while open.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, PIN_CODE, 0);
    step(1, 1, 1, 0, 0, 0);
    check("block_on", int'(alm_blkg), 1);
    check("block_gate_o", int'(gate_o), 0);
    step(1, 0, 1, 1, PIN_CODE, 0);
    check("block_hold", int'(alm_blkg), 1);
    step(1, 0, 0, 1, PIN_CODE, 0);
    check("block_exit", int'(alm_blkg), 0);

    // Open timeout without a car passing.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, PIN_CODE, 0);
    idle(OPEN_TIMEOUT - 1);
    check("timeout_still_open", int'(gate_o), 1);
    idle(1);
    check("timeout_closing", int'(gate_cls), 1);
    check("timeout_occ", int'(occupancy), 1);
    idle(CLOSE_CYCLES);

    // Fill the lot, then exercise full / cancel / drain behaviour.
    while (m_cars < CAPACITY) admit_car(0);
    check("full_flag", int'(lot_full), 1);
    check("full_count", int'(occupancy), CAPACITY);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, PIN_CODE, 0);
    check("full_no_open", int'(gate_o), 0);
    idle(1);
    step(1, 0, 0, 0, 0, 1);
    check("leave_count", int'(occupancy), CAPACITY - 1);
    check("leave_not_full", int'(lot_full), 0);
    admit_car(1);
    check("cancel_count", int'(occupancy), CAPACITY - 1);
    admit_car(0);
    check("refill_count", int'(occupancy), CAPACITY);
    for (int i = 0; i < CAPACITY; i++) step(1, 0, 0, 0, 0, 1);
    check("drained", int'(occupancy), 0);
    step(1, 0, 0, 0, 0, 1);
    check("empty_leave", int'(occupancy), 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      r_e   = ($urandom_range(0, 99) < 55) ? 1 : 0;
      r_x   = ($urandom_range(0, 99) < 25) ? 1 : 0;
      r_pv  = ($urandom_range(0, 99) < 25) ? 1 : 0;
      sel   = $urandom_range(0, 99);
      r_p   = (sel < 50) ? PIN_CODE : (sel < 75) ? PIN_CODE - 1 : int'($urandom_range(0, 255));
      r_cl  = ($urandom_range(0, 99) < 6) ? 1 : 0;
      r_rst = ($urandom_range(0, 599) == 0) ? 0 : 1;
      step(r_rst[0], r_e[0], r_x[0], r_pv[0], r_p, r_cl[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
